// File: rtl/ctrl_decode_queue.sv
// Purpose : decode fetched instructions on entry and buffer the decoded control bundle plus PC in a DEPTH-entry queue.
// Latency : 1 cycle from push to head; 0 cycles via bypass when CTRL_DECODE_QUEUE_BYPASS_EN is defined and the queue is empty.
// Backpr. : in_ready = (count < DEPTH) from registered state only; a full queue refuses a push even in a popping cycle.
//
// Optional feature macro: CTRL_DECODE_QUEUE_BYPASS_EN (empty-queue combinational bypass).
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_ir/in_pc     : fetch side handshake and instruction
//   flush                             : drop every buffered entry and any same-cycle push
//   out_valid/out_ready/out_pc        : execute side handshake and head PC
//   op_alu .. io_code                 : decoded control bundle of the head entry (0 while out_valid = 0)
//   occupancy                         : number of buffered entries, 0..DEPTH

`ifndef EXC_ILLEGAL_INST
`define EXC_ILLEGAL_INST 32'h0000_0002
`endif

// Purpose : combinational RV32I-style instruction decoder producing the control bundle.
// Latency : combinational.
// Backpr. : none; rst forces every output to 0.
module decoder (
  input  logic        rst,
  input  logic [31:0] ir,
  output logic [3:0]  op_alu,
  output logic        wrd_reg,
  output logic [4:0]  addr_d,
  output logic        rb_immed,
  output logic [31:0] imm,
  output logic        mem_to_reg,
  output logic        wrd_mem,
  output logic [2:0]  branch_code,
  output logic        is_a_jump,
  output logic        is_byte,
  output logic [1:0]  is_mov,
  output logic        illegal,
  output logic        is_tlbwrite,
  output logic        is_iret,
  output logic        is_ecall,
  output logic [6:0]  io_code
);
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd8;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};

  always_comb begin
    op_alu      = ALU_ADD;
    wrd_reg     = 1'b0;
    addr_d      = 5'd0;
    rb_immed    = 1'b0;
    imm         = 32'd0;
    mem_to_reg  = 1'b0;
    wrd_mem     = 1'b0;
    branch_code = 3'd0;
    is_a_jump   = 1'b0;
    is_byte     = 1'b0;
    is_mov      = 2'd0;
    illegal     = 1'b0;
    is_tlbwrite = 1'b0;
    is_iret     = 1'b0;
    is_ecall    = 1'b0;
    io_code     = 7'd0;
    if (!rst) begin
      case (opcode)
        7'h13: begin // register-immediate ALU
          if ((funct3 == 3'b001 && funct7 != 7'h00) ||
              (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) begin
            illegal = 1'b1;
          end else begin
            // only the right shift uses bit 30 to pick arithmetic vs logical
            op_alu   = {(funct3 == 3'b101) & ir[30], funct3};
            wrd_reg  = 1'b1;
            addr_d   = rd;
            rb_immed = 1'b1;
            imm      = imm_i;
          end
        end
        7'h33: begin // register-register ALU
          if (funct7 == 7'h00 ||
              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
            op_alu  = {funct7[5], funct3};
            wrd_reg = 1'b1;
            addr_d  = rd;
          end else begin
            illegal = 1'b1;
          end
        end
        7'h03: begin // loads
          if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
            illegal = 1'b1;
          end else begin
            wrd_reg    = 1'b1;
            addr_d     = rd;
            rb_immed   = 1'b1;
            imm        = imm_i;
            mem_to_reg = 1'b1;
            is_byte    = (funct3[1:0] == 2'b00);
          end
        end
        7'h23: begin // stores
          if (funct3 > 3'b010) begin
            illegal = 1'b1;
          end else begin
            wrd_mem  = 1'b1;
            rb_immed = 1'b1;
            imm      = imm_s;
            is_byte  = (funct3 == 3'b000);
          end
        end
        7'h63: begin // conditional branches, compared through the subtractor
          if (funct3 == 3'b010 || funct3 == 3'b011) begin
            illegal = 1'b1;
          end else begin
            op_alu = ALU_SUB;
            imm    = imm_b;
            // code 0 means "no branch", so the six conditions map to 1..6
            branch_code = funct3[2] ? (funct3 - 3'd1) : (funct3 + 3'd1);
          end
        end
        7'h6f: begin // jal
          is_a_jump = 1'b1;
          wrd_reg   = 1'b1;
          addr_d    = rd;
          imm       = imm_j;
        end
        7'h67: begin // jalr
          if (funct3 != 3'b000) begin
            illegal = 1'b1;
          end else begin
            is_a_jump = 1'b1;
            wrd_reg   = 1'b1;
            addr_d    = rd;
            rb_immed  = 1'b1;
            imm       = imm_i;
          end
        end
        7'h37, 7'h17: begin // lui (move 1) / auipc (move 2)
          is_mov   = (opcode == 7'h37) ? 2'd1 : 2'd2;
          wrd_reg  = 1'b1;
          addr_d   = rd;
          rb_immed = 1'b1;
          imm      = imm_u;
        end
        7'h73: begin // system
          if (ir == 32'h0000_0073) begin
            is_ecall = 1'b1;
          end else if (ir == 32'h3020_0073) begin
            is_iret = 1'b1;
          end else if (funct7 == 7'b0001001 && funct3 == 3'b000 && rd == 5'd0) begin
            is_tlbwrite = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        7'h0b: begin // I/O: funct3 0 = input to rd, 1 = output
          if (funct3 == 3'b000) begin
            io_code = funct7;
            wrd_reg = 1'b1;
            addr_d  = rd;
          end else if (funct3 == 3'b001) begin
            io_code = funct7;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end
endmodule

module ctrl_decode_queue #(
  parameter int               DEPTH       = 2,
  parameter int               EXC_W       = 32,
  parameter logic [EXC_W-1:0] EXC_ILLEGAL = EXC_W'(`EXC_ILLEGAL_INST)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ir,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [3:0]               op_alu,
  output logic                     wrd_reg,
  output logic [4:0]               addr_d,
  output logic                     rb_immed,
  output logic [31:0]              imm,
  output logic                     mem_to_reg,
  output logic                     wrd_mem,
  output logic [2:0]               branch_code,
  output logic                     is_a_jump,
  output logic                     is_byte,
  output logic [1:0]               is_mov,
  output logic [EXC_W-1:0]         is_illegal,
  output logic                     is_tlbwrite,
  output logic                     is_iret,
  output logic                     is_ecall,
  output logic [6:0]               io_code,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // The exception code is stored as one bit and widened only at the output.
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op_alu;
    logic        wrd_reg;
    logic [4:0]  addr_d;
    logic        rb_immed;
    logic [31:0] imm;
    logic        mem_to_reg;
    logic        wrd_mem;
    logic [2:0]  branch_code;
    logic        is_a_jump;
    logic        is_byte;
    logic [1:0]  is_mov;
    logic        illegal;
    logic        is_tlbwrite;
    logic        is_iret;
    logic        is_ecall;
    logic [6:0]  io_code;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             dec_entry;
  entry_t             head;
  entry_t             out_entry;
  logic               fifo_vld;
  logic               push;
  logic               store;
  logic               pop;
  logic               bypass;

  logic [3:0]  dec_op_alu;
  logic        dec_wrd_reg;
  logic [4:0]  dec_addr_d;
  logic        dec_rb_immed;
  logic [31:0] dec_imm;
  logic        dec_mem_to_reg;
  logic        dec_wrd_mem;
  logic [2:0]  dec_branch_code;
  logic        dec_is_a_jump;
  logic        dec_is_byte;
  logic [1:0]  dec_is_mov;
  logic        dec_illegal;
  logic        dec_is_tlbwrite;
  logic        dec_is_iret;
  logic        dec_is_ecall;
  logic [6:0]  dec_io_code;

  decoder u_decoder (
    .rst         (~rst),
    .ir          (in_ir),
    .op_alu      (dec_op_alu),
    .wrd_reg     (dec_wrd_reg),
    .addr_d      (dec_addr_d),
    .rb_immed    (dec_rb_immed),
    .imm         (dec_imm),
    .mem_to_reg  (dec_mem_to_reg),
    .wrd_mem     (dec_wrd_mem),
    .branch_code (dec_branch_code),
    .is_a_jump   (dec_is_a_jump),
    .is_byte     (dec_is_byte),
    .is_mov      (dec_is_mov),
    .illegal     (dec_illegal),
    .is_tlbwrite (dec_is_tlbwrite),
    .is_iret     (dec_is_iret),
    .is_ecall    (dec_is_ecall),
    .io_code     (dec_io_code)
  );

  always_comb begin
    dec_entry             = '0;
    dec_entry.pc          = in_pc;
    dec_entry.op_alu      = dec_op_alu;
    dec_entry.wrd_reg     = dec_wrd_reg;
    dec_entry.addr_d      = dec_addr_d;
    dec_entry.rb_immed    = dec_rb_immed;
    dec_entry.imm         = dec_imm;
    dec_entry.mem_to_reg  = dec_mem_to_reg;
    dec_entry.wrd_mem     = dec_wrd_mem;
    dec_entry.branch_code = dec_branch_code;
    dec_entry.is_a_jump   = dec_is_a_jump;
    dec_entry.is_byte     = dec_is_byte;
    dec_entry.is_mov      = dec_is_mov;
    dec_entry.illegal     = dec_illegal;
    dec_entry.is_tlbwrite = dec_is_tlbwrite;
    dec_entry.is_iret     = dec_is_iret;
    dec_entry.is_ecall    = dec_is_ecall;
    dec_entry.io_code     = dec_io_code;
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign fifo_vld  = (count_q != '0);
  assign occupancy = count_q;

`ifdef CTRL_DECODE_QUEUE_BYPASS_EN
  // Empty queue: present the incoming instruction directly. Gated by rst so
  // nothing is shown while the block is held in reset.
  assign bypass = rst && !fifo_vld && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push  = in_valid && in_ready && !flush;
  // A bypassed instruction that execute takes this cycle is never stored.
  assign store = push && !(bypass && out_ready);
  assign pop   = fifo_vld && out_ready;

  assign out_valid = fifo_vld || bypass;
  assign head      = bypass ? dec_entry : mem_q[rd_ptr_q];
  assign out_entry = out_valid ? head : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) begin
        mem_d[wr_ptr_q] = dec_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({store, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign out_pc      = out_entry.pc;
  assign op_alu      = out_entry.op_alu;
  assign wrd_reg     = out_entry.wrd_reg;
  assign addr_d      = out_entry.addr_d;
  assign rb_immed    = out_entry.rb_immed;
  assign imm         = out_entry.imm;
  assign mem_to_reg  = out_entry.mem_to_reg;
  assign wrd_mem     = out_entry.wrd_mem;
  assign branch_code = out_entry.branch_code;
  assign is_a_jump   = out_entry.is_a_jump;
  assign is_byte     = out_entry.is_byte;
  assign is_mov      = out_entry.is_mov;
  assign is_illegal  = out_entry.illegal ? EXC_ILLEGAL : '0;
  assign is_tlbwrite = out_entry.is_tlbwrite;
  assign is_iret     = out_entry.is_iret;
  assign is_ecall    = out_entry.is_ecall;
  assign io_code     = out_entry.io_code;
endmodule

// File: doc/ctrl_decode_queue.md
Name: ctrl_decode_queue

Overview:
- Registered, parametrised successor to the combinational control unit: instantiates the existing `decoder`, decodes each instruction on entry and buffers the decoded control bundle plus PC in a DEPTH-entry FIFO.
- Sits between fetch and execute; valid/ready handshakes on both sides decouple them.
- Adds pipeline flush and occupancy reporting.

Parameters:
- DEPTH, 2, number of buffered decoded entries; power of two, >=2.
- EXC_W, 32, width of the exception-code output.
- EXC_ILLEGAL, `EXC_ILLEGAL_INST, code driven on is_illegal for an illegal instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_ir  in  32  raw instruction word.
- in_pc  in  32  PC of in_ir.
- flush  in  1  discard all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  32  PC of head entry.
- op_alu  out  4  ALU operation.
- wrd_reg  out  1  register-file write enable.
- addr_d  out  5  destination register.
- rb_immed  out  1  operand B is the immediate.
- imm  out  32  sign-extended immediate.
- mem_to_reg  out  1  writeback from memory.
- wrd_mem  out  1  memory write enable.
- branch_code  out  3  branch condition.
- is_a_jump  out  1  jump.
- is_byte  out  1  byte access.
- is_mov  out  2  move type.
- is_illegal  out  EXC_W  EXC_ILLEGAL if illegal, else 0.
- is_tlbwrite  out  1  TLB write.
- is_iret  out  1  interrupt return.
- is_ecall  out  1  environment call.
- io_code  out  7  I/O operation code.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst=0, asynchronous): write pointer, read pointer and count = 0; out_valid = 0; occupancy = 0; every decoded output = 0.
- Push: in_valid && in_ready. The decoded bundle and in_pc are written at the write pointer; the write pointer wraps modulo DEPTH.
- Pop: out_valid && out_ready. The read pointer advances and wraps modulo DEPTH.
- in_ready = (count < DEPTH). It is a registered-state function only, with no combinational path from out_ready.
- out_valid = (count != 0).
- Latency: an instruction pushed in cycle N appears at the head in cycle N+1 at the earliest.
- Simultaneous push and pop: count unchanged. When full, a push cannot occur in the same cycle as a pop; in_ready only rises the cycle after the pop.
- Output gating: while out_valid = 0, every decoded output and out_pc read 0. They never show stale entry contents.
- Output stability: while out_valid = 1 && out_ready = 0, all outputs hold stable.
- Flush has priority over push and pop. The next edge sets both pointers and count to 0, drops any same-cycle push, and forces out_valid = 0 on the following cycle.
- Illegal instructions are buffered like any other entry; is_illegal carries EXC_ILLEGAL; wrd_reg and wrd_mem are whatever the decoder returns.
- Decoder rst input: driven high only while rst = 0.
- occupancy = count, range 0..DEPTH.
- Reset mid-operation: all entries are lost immediately; there is no partial retention.

Optional Feature:
- Macro: CTRL_DECODE_QUEUE_BYPASS_EN.
- Defined, bypass case: when count = 0 and in_valid = 1 (and flush = 0), the block decodes in_ir combinationally onto the outputs in the same cycle, with out_valid = 1 and out_pc = in_pc. The in_ready rule still holds.
- Defined, consume vs. store: if out_ready = 1, the instruction is consumed and not stored. Otherwise it is written into the FIFO as normal.
- Not defined: no bypass; minimum latency is 1 cycle.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> in_ready=1, out_valid=0, occupancy=0, all outputs 0; release and push addi x5,x0,7 (0x00700293) -> next cycle out_valid=1, addr_d=5, imm=7, wrd_reg=1, rb_immed=1.
- Fill with DEPTH=2 and out_ready=0: push 3 valid instructions back-to-back -> occupancy 1 then 2; in_ready=0 after the second push; third instruction not accepted and must be re-presented.
- Full with simultaneous handshakes: occupancy=2, out_ready=1 and in_valid=1 -> pop occurs, push refused that cycle; next cycle in_ready=1, then push accepted and order preserved (PCs 0x0,0x4,0x8 exit in order).
- Flush: occupancy=2 and same-cycle push -> next cycle occupancy=0, out_valid=0, dropped instruction never appears.
- Illegal: push 0xFFFFFFFF -> head shows is_illegal=EXC_ILLEGAL; then legal instruction shows is_illegal=0.
- Bypass (macro defined): empty queue, in_valid=1, out_ready=1 -> out_valid=1 same cycle with decoded fields, occupancy stays 0; macro undefined -> out_valid only in the next cycle.
